// File: rtl/light_phase_ctrl.sv
// Two-road traffic light phase sequencer driving an external seconds down-counter.
// Adds side-road demand latching and a maintenance flashing-yellow mode.
module light_phase_ctrl #(
  parameter int pRed_Count_Sec    = 18,
  parameter int pYellow_Count_Sec = 3,
  parameter int pGreen_Count_Sec  = 15,
  parameter int pAllRed_Count_Sec = 2,
  parameter int pCount_width      = $clog2(pRed_Count_Sec)
) (
  input  logic                    clk,
  input  logic                    rstb,
  input  logic                    en,
  input  logic                    sec_tick,
  input  logic                    light_tick,
  input  logic                    side_req,
  input  logic                    flash,
  output logic                    ctr_load,
  output logic [pCount_width-1:0] Load_Count,
  output logic                    main_r,
  output logic                    main_y,
  output logic                    main_g,
  output logic                    side_r,
  output logic                    side_y,
  output logic                    side_g,
  output logic [2:0]              phase
);

  typedef enum logic [2:0] {
    MG    = 3'd0,
    MY    = 3'd1,
    AR1   = 3'd2,
    SG    = 3'd3,
    SY    = 3'd4,
    AR2   = 3'd5,
    FLASH = 3'd6
  } state_e;

  localparam logic [pCount_width-1:0] GreenM1  = pCount_width'(pGreen_Count_Sec - 1);
  localparam logic [pCount_width-1:0] YellowM1 = pCount_width'(pYellow_Count_Sec - 1);
  localparam logic [pCount_width-1:0] AllRedM1 = pCount_width'(pAllRed_Count_Sec - 1);

  localparam bit DurLegal =
    (pGreen_Count_Sec  >= 2) && (pGreen_Count_Sec  <= pRed_Count_Sec) &&
    (pYellow_Count_Sec >= 2) && (pYellow_Count_Sec <= pRed_Count_Sec) &&
    (pAllRed_Count_Sec >= 2) && (pAllRed_Count_Sec <= pRed_Count_Sec);

  dur_legal_a: assert property (@(posedge clk) DurLegal);

  state_e     state_q, state_d;
  logic       dem_q, dem_d;
  logic       blink_q, blink_d;
  logic [5:0] lamps_q, lamps_d;   // {main_r, main_y, main_g, side_r, side_y, side_g}
  logic       tick_en, adv, pending;

  function automatic logic [pCount_width-1:0] dur_m1(state_e s);
    case (s)
      MG, SG:  dur_m1 = GreenM1;
      MY, SY:  dur_m1 = YellowM1;
      default: dur_m1 = AllRedM1;
    endcase
  endfunction

  always_comb begin
    tick_en = en & sec_tick;
    adv     = tick_en & light_tick;
    pending = dem_q | side_req;

    state_d = state_q;
    case (state_q)
      MG, MY, AR1, SG, SY, AR2: begin
        if (tick_en && flash) begin
          state_d = FLASH;
        end else if (adv) begin
          case (state_q)
            MG:      state_d = pending ? MY : MG;
            MY:      state_d = AR1;
            AR1:     state_d = SG;
            SG:      state_d = SY;
            SY:      state_d = AR2;
            default: state_d = MG;
          endcase
        end
      end
      FLASH:   if (tick_en && !flash) state_d = AR2;
      default: state_d = MG;
    endcase
    if (!rstb) state_d = state_q;

    // Clearing on SG entry beats a simultaneous new request.
    dem_d = dem_q | (side_req & (state_q != SG) & (state_q != SY));
    if (state_d == SG && state_q != SG) dem_d = 1'b0;

    blink_d = blink_q;
    if (state_q != FLASH && state_d == FLASH) blink_d = 1'b1;
    else if (state_q == FLASH && tick_en)     blink_d = ~blink_q;

    case (state_q)
      MG:       lamps_d = 6'b001_100;
      MY:       lamps_d = 6'b010_100;
      SG:       lamps_d = 6'b100_001;
      SY:       lamps_d = 6'b100_010;
      FLASH:    lamps_d = {1'b0, blink_q, 1'b0, 1'b0, blink_q, 1'b0};
      default:  lamps_d = 6'b100_100;
    endcase
  end

  // Load strobe: when high, the counter captures Load_Count on this rising edge and the
  // state register moves to the phase that load times; light_tick is the counter's
  // zero flag and is only honoured together with en & sec_tick.
  assign ctr_load   = rstb & en & sec_tick & (light_tick | flash | (state_q == FLASH));
  assign Load_Count = dur_m1(state_d);
  assign phase      = state_q;

  assign {main_r, main_y, main_g, side_r, side_y, side_g} = lamps_q;

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q <= MG;
      dem_q   <= 1'b0;
      blink_q <= 1'b0;
      lamps_q <= 6'b001_100;
    end else begin
      state_q <= state_d;
      dem_q   <= dem_d;
      blink_q <= blink_d;
      lamps_q <= lamps_d;
    end
  end

endmodule
